// File: rtl/ovl_hold_value_driver_pkg.sv
// Shared encodings for the OVL stimulus drivers: FSM state codes and error-injection codes.
package ovl_hold_value_driver_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_HOLD    = 2'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE = 2'd2;

    localparam logic [1:0] INJ_NONE  = 2'b00;
    localparam logic [1:0] INJ_SHORT = 2'b01;
    localparam logic [1:0] INJ_LONG  = 2'b10;

endpackage

// File: rtl/ovl_hold_len_calc.sv
// Combinational hold-length calculator: clamps the requested length into the legal window
// and, when asked and when representable, replaces it with a deliberately illegal length.
module ovl_hold_len_calc
    import ovl_hold_value_driver_pkg::*;
#(
    parameter int min       = 0,
    parameter int max       = 0,
    parameter int cnt_width = 8
)(
    input  logic [cnt_width-1:0] hold_len,
    input  logic [1:0]           inject_err,
    output logic [cnt_width-1:0] n_len,
    output logic                 injected
);

    localparam int MIN_EFF = (min < 1) ? 1 : min;
    localparam logic [cnt_width-1:0] MIN_C   = cnt_width'(MIN_EFF);
    localparam logic [cnt_width-1:0] MAX_C   = cnt_width'(max);
    localparam logic [cnt_width-1:0] SHORT_C = cnt_width'(min - 1);
    localparam logic [cnt_width-1:0] LONG_C  = cnt_width'(max + 1);
    localparam bit SHORT_OK = (min >= 2);
    // max+1 must still fit the counter, otherwise the too-long request degrades to legal
    localparam bit LONG_OK  = (max != 0) &&
                              ((longint'(max) + 1) <= ((longint'(1) << cnt_width) - 1));

    logic [cnt_width-1:0] len_lo;
    logic [cnt_width-1:0] len_legal;

    always_comb begin
        len_lo = (hold_len == '0) ? cnt_width'(1) : hold_len;
        if (len_lo < MIN_C)
            len_lo = MIN_C;
        len_legal = len_lo;
        if ((max != 0) && (len_lo > MAX_C))
            len_legal = MAX_C;

        n_len    = len_legal;
        injected = 1'b0;
        case (inject_err)
            INJ_SHORT: begin
                if (SHORT_OK) begin
                    n_len    = SHORT_C;
                    injected = 1'b1;
                end
            end
            INJ_LONG: begin
                if (LONG_OK) begin
                    n_len    = LONG_C;
                    injected = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ovl_hold_value_driver.sv
// Hold-value stimulus driver: holds a captured value for N cycles, then forces a transition
// away for one release cycle and pulses done.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | drive idle_value, wait for start
//  ST_HOLD    | drive captured value, cnt counts N..1
//  ST_RELEASE | drive captured idle_value (or ~value), done=1, one cycle
module ovl_hold_value_driver
    import ovl_hold_value_driver_pkg::*;
#(
    parameter int min         = 0,
    parameter int max         = 0,
    parameter int width       = 2,
    parameter int cnt_width   = 8,
    parameter int gating_type = 1
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [cnt_width-1:0] hold_len,
    input  logic [1:0]           inject_err,
    input  logic [width-1:0]     value,
    input  logic [width-1:0]     idle_value,
    output logic [width-1:0]     test_expr,
    output logic                 busy,
    output logic                 done,
    output logic                 injected
);

    logic [STATE_W-1:0]   state;
    logic [cnt_width-1:0] cnt;
    logic [width-1:0]     cap_value;
    logic [width-1:0]     cap_idle;
    logic [cnt_width-1:0] calc_n;
    logic                 calc_inj;
    logic                 clk_en;

    assign clk_en = (gating_type == 0) || enable;

    ovl_hold_len_calc #(
        .min       (min),
        .max       (max),
        .cnt_width (cnt_width)
    ) u_len_calc (
        .hold_len   (hold_len),
        .inject_err (inject_err),
        .n_len      (calc_n),
        .injected   (calc_inj)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_value <= '0;
            cap_idle  <= '0;
            test_expr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            injected  <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    test_expr <= idle_value;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    injected  <= 1'b0;
                    if (start) begin
                        state     <= ST_HOLD;
                        cnt       <= calc_n;
                        cap_value <= value;
                        cap_idle  <= idle_value;
                        test_expr <= value;
                        busy      <= 1'b1;
                        injected  <= calc_inj;
                    end
                end
                ST_HOLD: begin
                    test_expr <= cap_value;
                    cnt       <= cnt - 1'b1;
                    if (cnt == cnt_width'(1)) begin
                        state <= ST_RELEASE;
                        done  <= 1'b1;
                        // the release must differ from the held value for the checker to see it
                        test_expr <= (cap_idle == cap_value) ? ~cap_value : cap_idle;
                    end
                end
                ST_RELEASE: begin
                    state     <= ST_IDLE;
                    test_expr <= idle_value;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    injected  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ovl_hold_value_driver.sv
// Bench for ovl_hold_value_driver: four parameterisations share one stimulus stream and are
// compared every cycle against a queue-based timeline model of the expected outputs.
module tb_ovl_hold_value_driver;

    localparam int NI = 4;

    typedef struct packed {
        logic [1:0] te;
        logic       busy;
        logic       done;
        logic       inj;
    } ent_t;

    int P_MIN [NI] = '{2, 2, 0, 1};
    int P_MAX [NI] = '{5, 0, 0, 7};
    int P_CW  [NI] = '{8, 8, 8, 3};
    int P_G   [NI] = '{1, 1, 0, 1};

    logic       clock;
    logic       reset;
    logic       enable;
    logic       start;
    logic [7:0] hold_len;
    logic [1:0] inject_err;
    logic [1:0] value;
    logic [1:0] idle_value;

    logic [1:0] te_o   [NI];
    logic       busy_o [NI];
    logic       done_o [NI];
    logic       inj_o  [NI];

    ent_t exp_q [NI][$];
    ent_t cur [NI];
    bit   cur_idle [NI];

    int n_assert = 0;
    int n_fail   = 0;

    ovl_hold_value_driver #(.min(2), .max(5), .width(2), .cnt_width(8), .gating_type(1)) u_a (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .hold_len(hold_len),
        .inject_err(inject_err), .value(value), .idle_value(idle_value),
        .test_expr(te_o[0]), .busy(busy_o[0]), .done(done_o[0]), .injected(inj_o[0]));

    ovl_hold_value_driver #(.min(2), .max(0), .width(2), .cnt_width(8), .gating_type(1)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .hold_len(hold_len),
        .inject_err(inject_err), .value(value), .idle_value(idle_value),
        .test_expr(te_o[1]), .busy(busy_o[1]), .done(done_o[1]), .injected(inj_o[1]));

    ovl_hold_value_driver #(.min(0), .max(0), .width(2), .cnt_width(8), .gating_type(0)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .hold_len(hold_len),
        .inject_err(inject_err), .value(value), .idle_value(idle_value),
        .test_expr(te_o[2]), .busy(busy_o[2]), .done(done_o[2]), .injected(inj_o[2]));

    ovl_hold_value_driver #(.min(1), .max(7), .width(2), .cnt_width(3), .gating_type(1)) u_d (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .hold_len(hold_len[2:0]),
        .inject_err(inject_err), .value(value), .idle_value(idle_value),
        .test_expr(te_o[3]), .busy(busy_o[3]), .done(done_o[3]), .injected(inj_o[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_len(input int i, input int hl_in, input logic [1:0] ie,
                                      output int n, output logic inj);
        int lim;
        int hl;
        int lo;
        int l;
        lim = (1 << P_CW[i]) - 1;
        hl  = hl_in & lim;
        lo  = (P_MIN[i] < 1) ? 1 : P_MIN[i];
        l   = (hl < 1) ? 1 : hl;
        if (l < lo) l = lo;
        if (P_MAX[i] != 0 && l > P_MAX[i]) l = P_MAX[i];
        n   = l;
        inj = 1'b0;
        if (ie == 2'b01 && P_MIN[i] >= 2) begin
            n   = P_MIN[i] - 1;
            inj = 1'b1;
        end
        if (ie == 2'b10 && P_MAX[i] != 0 && P_MAX[i] + 1 <= lim) begin
            n   = P_MAX[i] + 1;
            inj = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            cur[i]      = '0;
            cur_idle[i] = 1'b1;
        end
    endfunction

    // One active clock edge of the expected timeline: a sequence is a list of N hold
    // entries plus one release entry, consumed one per enabled cycle.
    function automatic void model_edge();
        int   n;
        logic inj;
        ent_t e;
        logic [1:0] rel;
        for (int i = 0; i < NI; i++) begin
            if (P_G[i] == 0 || enable) begin
                if (cur_idle[i]) begin
                    if (start) begin
                        model_len(i, int'(hold_len), inject_err, n, inj);
                        rel = (idle_value == value) ? ~value : idle_value;
                        for (int k = 0; k < n; k++) begin
                            e = '{te: value, busy: 1'b1, done: 1'b0, inj: inj};
                            exp_q[i].push_back(e);
                        end
                        e = '{te: rel, busy: 1'b1, done: 1'b1, inj: inj};
                        exp_q[i].push_back(e);
                        cur[i]      = exp_q[i].pop_front();
                        cur_idle[i] = 1'b0;
                    end else begin
                        cur[i] = '{te: idle_value, busy: 1'b0, done: 1'b0, inj: 1'b0};
                    end
                end else if (exp_q[i].size() > 0) begin
                    cur[i] = exp_q[i].pop_front();
                end else begin
                    cur[i]      = '{te: idle_value, busy: 1'b0, done: 1'b0, inj: 1'b0};
                    cur_idle[i] = 1'b1;
                end
            end
        end
    endfunction

    function automatic bit model_idle();
        bit r = 1'b1;
        for (int i = 0; i < NI; i++)
            if (!cur_idle[i] || exp_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    function automatic bit any_busy();
        bit r = 1'b0;
        for (int i = 0; i < NI; i++)
            if (busy_o[i]) r = 1'b1;
        return r;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < NI; i++) begin
            n_assert++;
            assert (te_o[i] === cur[i].te) else begin
                n_fail++;
                $error("FAIL %s test_expr[%0d] t=%0t got %b expected %b", tag, i, $time, te_o[i], cur[i].te);
            end
            n_assert++;
            assert (busy_o[i] === cur[i].busy) else begin
                n_fail++;
                $error("FAIL %s busy[%0d] t=%0t got %b expected %b", tag, i, $time, busy_o[i], cur[i].busy);
            end
            n_assert++;
            assert (done_o[i] === cur[i].done) else begin
                n_fail++;
                $error("FAIL %s done[%0d] t=%0t got %b expected %b", tag, i, $time, done_o[i], cur[i].done);
            end
            n_assert++;
            assert (inj_o[i] === cur[i].inj) else begin
                n_fail++;
                $error("FAIL %s injected[%0d] t=%0t got %b expected %b", tag, i, $time, inj_o[i], cur[i].inj);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        if (!reset) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((any_busy() || !model_idle()) && k < budget) begin
            step(tag);
            k++;
        end
        n_assert++;
        assert (k < budget) else begin
            n_fail++;
            $error("FAIL %s idle_timeout got %0d cycles expected < %0d", tag, k, budget);
        end
    endtask

    task automatic run_seq(input string tag, input logic [7:0] hl, input logic [1:0] ie,
                           input logic [1:0] v, input logic [1:0] iv);
        hold_len   = hl;
        inject_err = ie;
        value      = v;
        idle_value = iv;
        start      = 1'b1;
        step(tag);
        start      = 1'b0;
        value      = ~v;
        hold_len   = 8'd1;
        wait_idle(tag, 40);
        step(tag);
    endtask

    initial begin
        int hold_cnt;
        int done_cnt;
        int gap;
        int seen_gaps;
        int k;

        reset = 1'b0; enable = 1'b1; start = 1'b0;
        hold_len = 8'd0; inject_err = 2'b00; value = 2'b00; idle_value = 2'b00;
        model_reset();

        #2 reset = 1'b1;
        #1 check_all("reset_async");
        step("reset_held");
        reset = 1'b0;
        idle_value = 2'b11;
        step("idle");
        step("idle");

        run_seq("basic_len3", 8'd3, 2'b00, 2'b01, 2'b10);
        run_seq("len0_clamp", 8'd0, 2'b00, 2'b10, 2'b00);
        run_seq("len9_clamp", 8'd9, 2'b00, 2'b11, 2'b01);
        run_seq("inj_short", 8'd4, 2'b01, 2'b01, 2'b00);
        run_seq("inj_long", 8'd3, 2'b10, 2'b10, 2'b01);
        run_seq("inj_11_none", 8'd4, 2'b11, 2'b11, 2'b00);

        // Release must force a transition when idle_value equals value.
        hold_len = 8'd2; inject_err = 2'b00; value = 2'b10; idle_value = 2'b10;
        start = 1'b1;
        step("same_val");
        start = 1'b0;
        k = 0;
        while (!done_o[0] && k < 20) begin
            step("same_val");
            k++;
        end
        n_assert++;
        assert (done_o[0] === 1'b1 && te_o[0] === 2'b01) else begin
            n_fail++;
            $error("FAIL release_invert got te=%b done=%b expected te=01 done=1", te_o[0], done_o[0]);
        end
        wait_idle("same_val", 40);

        // Start held high: back-to-back sequences separated by one IDLE cycle.
        hold_len = 8'd2; value = 2'b01; idle_value = 2'b10; start = 1'b1;
        gap = -1; seen_gaps = 0;
        for (int c = 0; c < 30; c++) begin
            step("b2b");
            if (gap >= 0) begin
                if (busy_o[0]) begin
                    n_assert++;
                    assert (gap == 1) else begin
                        n_fail++;
                        $error("FAIL b2b_gap got %0d idle cycles expected 1", gap);
                    end
                    seen_gaps++;
                    gap = -1;
                end else begin
                    gap++;
                end
            end
            if (done_o[0]) gap = 0;
        end
        n_assert++;
        assert (seen_gaps >= 3) else begin
            n_fail++;
            $error("FAIL b2b_count got %0d restarts expected >= 3", seen_gaps);
        end
        start = 1'b0;
        wait_idle("b2b", 40);
        step("b2b");

        // Freeze for 4 cycles mid-HOLD: hold of 3 becomes 7 observed cycles.
        hold_len = 8'd3; value = 2'b11; idle_value = 2'b00; start = 1'b1;
        hold_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) start = 1'b0;
            if (c == 2) enable = 1'b0;
            if (c == 6) enable = 1'b1;
            step("freeze_hold");
            if (busy_o[0] && !done_o[0]) hold_cnt++;
        end
        n_assert++;
        assert (hold_cnt == 7) else begin
            n_fail++;
            $error("FAIL freeze_hold_len got %0d expected 7", hold_cnt);
        end
        wait_idle("freeze_hold", 40);

        // Freeze during RELEASE stretches done.
        hold_len = 8'd2; value = 2'b01; idle_value = 2'b11; start = 1'b1;
        step("freeze_rel");
        start = 1'b0;
        k = 0;
        while (!done_o[0] && k < 20) begin
            step("freeze_rel");
            k++;
        end
        done_cnt = 1;
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step("freeze_rel");
            if (done_o[0]) done_cnt++;
        end
        enable = 1'b1;
        step("freeze_rel");
        if (done_o[0]) done_cnt++;
        n_assert++;
        assert (done_cnt == 4) else begin
            n_fail++;
            $error("FAIL done_stretch got %0d expected 4", done_cnt);
        end
        wait_idle("freeze_rel", 40);

        // Reset in the middle of HOLD aborts without a done pulse.
        hold_len = 8'd5; value = 2'b10; idle_value = 2'b01; start = 1'b1;
        step("rst_mid");
        start = 1'b0;
        step("rst_mid");
        #3 reset = 1'b1;
        model_reset();
        #1 check_all("rst_mid_async");
        step("rst_mid_held");
        step("rst_mid_held");
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step("rst_after");
            if (done_o[0]) done_cnt++;
        end
        n_assert++;
        assert (done_cnt == 0) else begin
            n_fail++;
            $error("FAIL rst_no_done got %0d done pulses expected 0", done_cnt);
        end

        for (int c = 0; c < 500; c++) begin
            start      = ($urandom_range(0, 3) == 0);
            hold_len   = 8'($urandom_range(0, 10));
            inject_err = 2'($urandom_range(0, 3));
            value      = 2'($urandom_range(0, 3));
            idle_value = ($urandom_range(0, 3) == 0) ? value : 2'($urandom_range(0, 3));
            enable     = ($urandom_range(0, 4) != 0);
            step("random");
        end
        enable = 1'b1;
        start  = 1'b0;
        wait_idle("random_drain", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
